// File: rtl/timer_capture_if.sv
// Capture-unit bus: timer count, capture pin and CPU FIFO/period signals.
// The slave modport is the capture unit; the master modport is whoever drives the pin and reads results.
interface timer_capture_if #(
    parameter int BIT = 32
);
    logic [BIT-1:0] i_count;
    logic           i_cap_in;
    logic [1:0]     i_edge_sel;
    logic           i_rd;
    logic           i_ovf_clr;
    logic [BIT-1:0] o_data;
    logic           o_valid;
    logic           o_full;
    logic           o_ovf;
    logic [BIT-1:0] o_period;
    logic           o_period_vld;

    modport master (
        output i_count, i_cap_in, i_edge_sel, i_rd, i_ovf_clr,
        input  o_data, o_valid, o_full, o_ovf, o_period, o_period_vld
    );

    modport slave (
        input  i_count, i_cap_in, i_edge_sel, i_rd, i_ovf_clr,
        output o_data, o_valid, o_full, o_ovf, o_period, o_period_vld
    );
endinterface

// File: rtl/timer_capture.sv
// Input capture: timestamps qualified pin edges 2 clocks after the pin changes, queues them, tracks the interval.
// A capture is dropped and Ovf is set when the FIFO is full and not popped in the same cycle.
module timer_capture #(
    parameter int BIT   = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    timer_capture_if.slave bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [BIT-1:0] WRAP_ADJ = {1'b0, {(BIT - 1){1'b1}}};

    logic           r_s1, r_s2, r_s3;
    logic           w_rise, w_fall, w_hit;
    logic [BIT-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
    logic [AW:0]    r_cnt;
    logic           w_full, w_valid, w_pop, w_push, w_drop;
    logic           r_ovf;
    logic [BIT-1:0] r_last, r_period;
    logic           r_first, r_pvld;
    logic [BIT-1:0] w_diff, w_interval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.i_cap_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise  = r_s2 & ~r_s3;
    assign w_fall  = ~r_s2 & r_s3;
    assign w_hit   = (w_rise & bus.i_edge_sel[0]) | (w_fall & bus.i_edge_sel[1]);

    assign w_valid = (r_cnt != '0);
    assign w_full  = (r_cnt == FULL_CNT);
    assign w_pop   = bus.i_rd & w_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the new stamp
    assign w_push  = w_hit & (~w_full | w_pop);
    assign w_drop  = w_hit & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.i_count;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // The timer counts up to 2^(BIT-1)-1 then restarts at 1, so a wrap spans that many ticks
    assign w_diff     = bus.i_count - r_last;
    assign w_interval = (bus.i_count >= r_last) ? w_diff : (w_diff + WRAP_ADJ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= '0;
            r_period <= '0;
            r_first  <= 1'b0;
            r_pvld   <= 1'b0;
        end else if (w_hit) begin
            r_last  <= bus.i_count;
            r_first <= 1'b1;
            if (r_first) begin
                r_period <= w_interval;
                r_pvld   <= 1'b1;
            end
        end
    end

    assign bus.o_data       = r_mem[r_rd_ptr];
    assign bus.o_valid      = w_valid;
    assign bus.o_full       = w_full;
    assign bus.o_ovf        = r_ovf;
    assign bus.o_period     = r_period;
    assign bus.o_period_vld = r_pvld;
endmodule
